// File: rtl/jpl_foc_pkg.sv
// rtl/jpl_foc_pkg.sv - shared types and defaults for the Clarke engine scheduler
package jpl_foc_pkg;

    localparam int B_DEF       = 12;
    localparam int N_DEF       = 3;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [B_DEF-1:0] ia;
        logic [B_DEF-1:0] ib;
        logic             pending;
    } slot_t;

endpackage

// File: rtl/jpl_foc_rr_arbiter.sv
// rtl/jpl_foc_rr_arbiter.sv - round-robin pick of the first pending axis at or after ptr
module jpl_foc_rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW:0] cand;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            // ptr < N, so one conditional subtract is enough to wrap
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (en && !found && req[cand[IW-1:0]]) begin
                found              = 1'b1;
                idx                = cand[IW-1:0];
                grant[cand[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jpl_foc_clarke_sched.sv
// rtl/jpl_foc_clarke_sched.sv - shares one Clarke engine among N axes in round-robin order
module jpl_foc_clarke_sched
    import jpl_foc_pkg::*;
#(
    parameter int B       = B_DEF,
    parameter int N       = N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req,
    input  logic [N*B-1:0] i_ia,
    input  logic [N*B-1:0] i_ib,
    output logic           o_eng_start,
    output logic [B-1:0]   o_eng_ia,
    output logic [B-1:0]   o_eng_ib,
    input  logic           i_eng_done,
    input  logic [B-1:0]   i_eng_ialpha,
    input  logic [B-1:0]   i_eng_ibeta,
    output logic [N-1:0]   o_valid,
    output logic [B-1:0]   o_ialpha,
    output logic [B-1:0]   o_ibeta,
    output logic [N-1:0]   o_overrun,
    output logic [N-1:0]   o_timeout,
    output logic           o_busy
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_next;
    logic [B-1:0]  slot_ia [N];
    logic [B-1:0]  slot_ib [N];
    logic [N-1:0]  pending;
    logic [IW-1:0] ptr;
    logic [IW-1:0] cur;
    logic [CW-1:0] cnt;
    logic [N-1:0]  arb_grant;
    logic [IW-1:0] arb_idx;
    logic          wait_expired;

    jpl_foc_rr_arbiter #(.N(N)) u_arb (
        .req   (pending),
        .ptr   (ptr),
        .en    (state == ST_GRANT),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // A done in the last counted cycle wins over the timeout
    assign wait_expired = (state == ST_WAIT) && !i_eng_done && (cnt >= CW'(TIMEOUT - 1));

    // A new request in the grant cycle of the same axis re-arms the slot without overrun
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < N; n++) begin
                slot_ia[n] <= '0;
                slot_ib[n] <= '0;
            end
            pending   <= '0;
            o_overrun <= '0;
        end else begin
            for (int n = 0; n < N; n++) begin
                if (i_req[n]) begin
                    slot_ia[n] <= i_ia[n*B +: B];
                    slot_ib[n] <= i_ib[n*B +: B];
                end
            end
            pending   <= i_req | (pending & ~arb_grant);
            o_overrun <= i_req & pending & ~arb_grant;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if ((|pending) || (|i_req)) state_next = ST_GRANT;
            ST_GRANT: state_next = (|arb_grant) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (i_eng_done) begin
                    state_next = ST_RESP;
                end else if (wait_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_eng_start = 1'b0;
        o_busy      = 1'b0;
        o_valid     = '0;
        o_eng_start = (state == ST_ISSUE);
        o_busy      = (state != ST_IDLE);
        if (state == ST_RESP) begin
            o_valid = N'(1) << cur;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
            o_eng_ia  <= '0;
            o_eng_ib  <= '0;
            o_ialpha  <= '0;
            o_ibeta   <= '0;
            o_timeout <= '0;
        end else begin
            o_timeout <= '0;
            if ((state == ST_GRANT) && (|arb_grant)) begin
                cur      <= arb_idx;
                ptr      <= (arb_idx == IW'(N - 1)) ? '0 : arb_idx + 1'b1;
                o_eng_ia <= slot_ia[arb_idx];
                o_eng_ib <= slot_ib[arb_idx];
            end
            if (state == ST_ISSUE) begin
                cnt <= '0;
            end else if ((state == ST_WAIT) && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == ST_WAIT) && i_eng_done) begin
                o_ialpha <= i_eng_ialpha;
                o_ibeta  <= i_eng_ibeta;
            end
            if (wait_expired) begin
                o_timeout <= N'(1) << cur;
            end
        end
    end

endmodule

// File: tb/tb_jpl_foc_clarke_sched.sv
// tb/tb_jpl_foc_clarke_sched.sv - directed bench for jpl_foc_clarke_sched with a 4-cycle engine model
module tb_jpl_foc_clarke_sched;

    localparam int B       = 12;
    localparam int N       = 3;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*B-1:0] ia  = '0;
    logic [N*B-1:0] ib  = '0;
    logic           eng_start;
    logic [B-1:0]   eng_ia;
    logic [B-1:0]   eng_ib;
    logic           eng_done  = 1'b0;
    logic [B-1:0]   eng_alpha = '0;
    logic [B-1:0]   eng_beta  = '0;
    logic [N-1:0]   valid;
    logic [B-1:0]   ialpha;
    logic [B-1:0]   ibeta;
    logic [N-1:0]   overrun;
    logic [N-1:0]   timeout_v;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int eng_lat     = 4;
    bit eng_mute    = 1'b0;
    int eng_cd      = -1;

    int           res_cyc[$];
    logic [N-1:0] res_v[$];
    logic [B-1:0] res_a[$];
    logic [B-1:0] res_b[$];
    int           st_cyc[$];
    logic [B-1:0] st_ia[$];
    logic [B-1:0] st_ib[$];
    int           to_cyc[$];
    logic [N-1:0] to_v[$];
    logic [N-1:0] ov_v[$];

    jpl_foc_clarke_sched #(.B(B), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_ia         (ia),
        .i_ib         (ib),
        .o_eng_start  (eng_start),
        .o_eng_ia     (eng_ia),
        .o_eng_ib     (eng_ib),
        .i_eng_done   (eng_done),
        .i_eng_ialpha (eng_alpha),
        .i_eng_ibeta  (eng_beta),
        .o_valid      (valid),
        .o_ialpha     (ialpha),
        .o_ibeta      (ibeta),
        .o_overrun    (overrun),
        .o_timeout    (timeout_v),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine: done eng_lat cycles after the start cycle, alpha = ia, beta = ia + ib
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (rst) begin
            eng_cd <= -1;
        end else if (eng_start) begin
            eng_cd <= eng_lat - 2;
        end else if (eng_cd > 0) begin
            eng_cd <= eng_cd - 1;
        end else if (eng_cd == 0) begin
            eng_cd <= -1;
            if (!eng_mute) begin
                eng_done  <= 1'b1;
                eng_alpha <= eng_ia;
                eng_beta  <= eng_ia + eng_ib;
            end
        end
    end

    always @(negedge clk) begin
        if (valid != '0) begin
            res_cyc.push_back(cyc); res_v.push_back(valid);
            res_a.push_back(ialpha); res_b.push_back(ibeta);
        end
        if (eng_start) begin
            st_cyc.push_back(cyc); st_ia.push_back(eng_ia); st_ib.push_back(eng_ib);
        end
        if (timeout_v != '0) begin
            to_cyc.push_back(cyc); to_v.push_back(timeout_v);
        end
        if (overrun != '0) ov_v.push_back(overrun);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_axis(input int n, input int a, input int b);
        ia[n*B +: B] = B'(a);
        ib[n*B +: B] = B'(b);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic clear_q();
        res_cyc.delete(); res_v.delete(); res_a.delete(); res_b.delete();
        st_cyc.delete(); st_ia.delete(); st_ib.delete();
        to_cyc.delete(); to_v.delete(); ov_v.delete();
    endtask

    task automatic wait_res(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && res_v.size() < n; i++) tick();
        ok = (res_v.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if ({busy, eng_start, valid, overrun, timeout_v} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b expected 0", {busy, eng_start, valid, overrun, timeout_v});
        end
        vectors++;
        if ({eng_ia, eng_ib, ialpha, ibeta} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got %h expected 0", {eng_ia, eng_ib, ialpha, ibeta});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic check_order(input string name, input logic [N-1:0] ev[3],
                               input logic [B-1:0] ea[3], input logic [B-1:0] eb[3]);
        bit ok;
        wait_res(3, 60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_count got %0d results expected 3", name, res_v.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if ({res_v[i], res_a[i], res_b[i]} !== {ev[i], ea[i], eb[i]}) begin
                    miscompares++;
                    $display("FAIL %s_res%0d got v=%b a=%h b=%h expected v=%b a=%h b=%h",
                             name, i, res_v[i], res_a[i], res_b[i], ev[i], ea[i], eb[i]);
                end
            end
        end
    endtask

    task automatic test_fair();
        logic [N-1:0] ev[3];
        logic [B-1:0] ea[3];
        logic [B-1:0] eb[3];
        ev[0] = 3'b001; ev[1] = 3'b010; ev[2] = 3'b100;
        for (int rep = 0; rep < 2; rep++) begin
            clear_q();
            if (rep == 0) begin
                set_axis(0, 10, 1); set_axis(1, 20, 2); set_axis(2, 30, 3);
                ea[0] = B'(10); ea[1] = B'(20); ea[2] = B'(30);
                eb[0] = B'(11); eb[1] = B'(22); eb[2] = B'(33);
            end else begin
                set_axis(0, -40, 5); set_axis(1, 7, -8); set_axis(2, 300, -100);
                ea[0] = B'(-40); ea[1] = B'(7);  ea[2] = B'(300);
                eb[0] = B'(-35); eb[1] = B'(-1); eb[2] = B'(200);
            end
            pulse(3'b111);
            check_order($sformatf("fair%0d", rep), ev, ea, eb);
            vectors++;
            if (ov_v.size() != 0) begin
                miscompares++;
                $display("FAIL fair%0d_overrun got %0d pulses expected 0", rep, ov_v.size());
            end
            tick(); tick();
        end
    endtask

    task automatic test_single();
        int c;
        bit ok;
        clear_q();
        c = cyc;
        set_axis(0, 100, 50);
        pulse(3'b001);
        wait_res(1, 20, ok);
        vectors++;
        if (!ok || st_cyc.size() != 1) begin
            miscompares++;
            $display("FAIL single_count got %0d results %0d starts expected 1 1", res_v.size(), st_cyc.size());
        end else begin
            vectors++;
            if ({st_ia[0], st_ib[0]} !== {B'(100), B'(50)} || st_cyc[0] != c + 2) begin
                miscompares++;
                $display("FAIL single_start got ia=%0d ib=%0d at +%0d expected 100 50 at +2",
                         st_ia[0], st_ib[0], st_cyc[0] - c);
            end
            vectors++;
            if ({res_v[0], res_a[0], res_b[0]} !== {3'b001, B'(100), B'(150)} || res_cyc[0] != c + 7) begin
                miscompares++;
                $display("FAIL single_result got v=%b a=%0d b=%0d at +%0d expected 001 100 150 at +7",
                         res_v[0], res_a[0], res_b[0], res_cyc[0] - c);
            end
        end
        repeat (4) tick();
        vectors++;
        if ({valid, ialpha, ibeta} !== {3'b000, B'(100), B'(150)}) begin
            miscompares++;
            $display("FAIL single_hold got v=%b a=%0d b=%0d expected 000 100 150", valid, ialpha, ibeta);
        end
    endtask

    task automatic test_overrun();
        logic [N-1:0] ev[3];
        logic [B-1:0] ea[3];
        logic [B-1:0] eb[3];
        bit ok;
        clear_q();
        set_axis(0, 1, 1);
        pulse(3'b001);
        tick();
        set_axis(1, 50, -5);
        pulse(3'b010);
        set_axis(1, 50, -7);
        pulse(3'b010);
        wait_res(2, 40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL overrun_count got %0d results expected 2", res_v.size());
        end else begin
            ev[0] = 3'b001; ea[0] = B'(1);  eb[0] = B'(2);
            ev[1] = 3'b010; ea[1] = B'(50); eb[1] = B'(43);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({res_v[i], res_a[i], res_b[i]} !== {ev[i], ea[i], eb[i]}) begin
                    miscompares++;
                    $display("FAIL overrun_res%0d got v=%b a=%0d b=%0d expected v=%b a=%0d b=%0d",
                             i, res_v[i], res_a[i], res_b[i], ev[i], ea[i], eb[i]);
                end
            end
        end
        vectors++;
        if (ov_v.size() != 1 || (ov_v.size() == 1 && ov_v[0] !== 3'b010)) begin
            miscompares++;
            $display("FAIL overrun_pulse got %0d pulses expected one on axis 1", ov_v.size());
        end
        tick(); tick();
    endtask

    task automatic test_grant_collision();
        bit ok;
        clear_q();
        set_axis(0, 5, 6);
        pulse(3'b001);
        set_axis(0, 9, 10);
        pulse(3'b001);
        wait_res(2, 40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL collide_count got %0d results expected 2", res_v.size());
        end else begin
            vectors++;
            if ({res_v[0], res_a[0], res_b[0], res_v[1], res_a[1], res_b[1]} !==
                {3'b001, B'(5), B'(11), 3'b001, B'(9), B'(19)}) begin
                miscompares++;
                $display("FAIL collide_res got %b/%0d/%0d %b/%0d/%0d expected 001/5/11 001/9/19",
                         res_v[0], res_a[0], res_b[0], res_v[1], res_a[1], res_b[1]);
            end
        end
        vectors++;
        if (ov_v.size() != 0) begin
            miscompares++;
            $display("FAIL collide_overrun got %0d pulses expected 0", ov_v.size());
        end
        tick(); tick();
    endtask

    task automatic test_timeout();
        int c;
        for (int v = 0; v < 3; v++) begin
            clear_q();
            eng_mute = (v == 0);
            eng_lat  = (v == 1) ? 64 : 65;
            c = cyc;
            set_axis(v == 1 ? 1 : 2, 3, 4);
            pulse(v == 1 ? 3'b010 : 3'b100);
            repeat (80) tick();
            if (v == 1) begin
                vectors++;
                if (res_v.size() != 1 || to_v.size() != 0) begin
                    miscompares++;
                    $display("FAIL timeout_edge got %0d results %0d timeouts expected 1 0", res_v.size(), to_v.size());
                end else begin
                    vectors++;
                    if ({res_v[0], res_a[0], res_b[0]} !== {3'b010, B'(3), B'(7)} || res_cyc[0] != c + 67) begin
                        miscompares++;
                        $display("FAIL timeout_edge_res got v=%b a=%0d b=%0d at +%0d expected 010 3 7 at +67",
                                 res_v[0], res_a[0], res_b[0], res_cyc[0] - c);
                    end
                end
            end else begin
                vectors++;
                if (res_v.size() != 0 || to_v.size() != 1) begin
                    miscompares++;
                    $display("FAIL timeout%0d got %0d results %0d timeouts expected 0 1", v, res_v.size(), to_v.size());
                end else begin
                    vectors++;
                    if (to_v[0] !== 3'b100 || to_cyc[0] != c + 67) begin
                        miscompares++;
                        $display("FAIL timeout%0d_pulse got %b at +%0d expected 100 at +67", v, to_v[0], to_cyc[0] - c);
                    end
                end
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout%0d_idle got busy=%b expected 0", v, busy);
            end
        end
        eng_mute = 1'b0;
        eng_lat  = 4;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ev[3];
        logic [B-1:0] ea[3];
        logic [B-1:0] eb[3];
        clear_q();
        set_axis(1, 1, 2);
        pulse(3'b010);
        tick(); tick(); tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy got %b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, eng_start, valid, overrun, timeout_v} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_ctrl got %b expected 0", {busy, eng_start, valid, overrun, timeout_v});
        end
        vectors++;
        if ({eng_ia, eng_ib, ialpha, ibeta} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_data got %h expected 0", {eng_ia, eng_ib, ialpha, ibeta});
        end
        tick(); tick();
        rst = 1'b0;
        clear_q();
        repeat (12) tick();
        vectors++;
        if (res_v.size() != 0 || st_cyc.size() != 0 || to_v.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_silent got %0d results %0d starts %0d timeouts expected 0 0 0",
                     res_v.size(), st_cyc.size(), to_v.size());
        end
        set_axis(0, 21, 1); set_axis(1, 22, 2); set_axis(2, 23, 3);
        ev[0] = 3'b001; ev[1] = 3'b010; ev[2] = 3'b100;
        ea[0] = B'(21); ea[1] = B'(22); ea[2] = B'(23);
        eb[0] = B'(22); eb[1] = B'(24); eb[2] = B'(26);
        pulse(3'b111);
        check_order("rstmid", ev, ea, eb);
    endtask

    initial begin
        test_reset();
        test_fair();
        test_single();
        test_overrun();
        test_grant_collision();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
